bsg_wormhole_test_node_client: RTL and testbench
================================================

Name: bsg_wormhole_test_node_client

Overview:
- Loopback client endpoint for the wormhole network test bench; the far end of the test master node.
- Per net, it accepts wormhole packets from the router and rewrites the header cord to the return cord.
- It sends every flit back unchanged apart from the header cord, so the master's data checker sees its own generated sequence.
- Supports multi-flit packets (len > 0), per-net stall control and packet counters.

Parameters:
- flit_width_p, "inv", flit width in bits.
- cord_width_p, "inv", header cord field width; cord occupies flit[cord_width_p-1:0].
- len_width_p, "inv", header len field width; len occupies flit[cord_width_p+:len_width_p].
- num_nets_p, 2, number of independent networks (one loopback channel each).
- fifo_els_p, 2, input buffer depth per net; minimum 2, power of two.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  num_nets_p  per-net enable; 0 stalls output launch of new packets.
- my_cord_i  in  cord_width_p  this node's coordinate, used only by the optional check.
- return_cord_i  in  cord_width_p  coordinate written into returned headers.
- link_i  in  num_nets_p x ready_and_link width(flit_width_p)  router-to-node links (v, data, ready_and_rev).
- link_o  out  num_nets_p x ready_and_link width(flit_width_p)  node-to-router links.
- packets_o  out  num_nets_p x 32  completed returned packets per net.
- busy_o  out  num_nets_p  net is mid-packet (state BODY).
- error_o  out  num_nets_p  sticky error, optional feature only.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Reset applies to all state:
  - FIFOs empty, all FSMs in IDLE;
  - link_o.v=0, link_o.ready_and_rev=0 while reset is asserted;
  - packets_o=0, busy_o=0, error_o=0.
- Input side per net:
  - fifo_els_p-deep FIFO.
  - link_o.ready_and_rev = FIFO not full.
  - A flit is enqueued when link_i.v & ready.
- Output side per net:
  - Output register (one flit) drives link_o.v/data.
  - Register is consumed when link_o.v & link_i.ready_and_rev.
  - Register may be refilled in the same cycle it is consumed (full throughput, 1 flit/cycle).
- FSM per net, IDLE / BODY:
  - IDLE: if FIFO non-empty, en_i=1 and the output register is free or draining:
    - dequeue the head flit;
    - load the output register with the flit, cord field replaced by return_cord_i, len and data unchanged;
    - capture len into remaining counter;
    - if len==0: packets_o++ and stay in IDLE; else go to BODY.
  - BODY: on each dequeue, forward the flit unmodified and decrement remaining; when remaining==1 at dequeue, packets_o++ and go to IDLE.
  - BODY ignores en_i: a packet in progress always completes, so the wormhole is never blocked mid-packet.
- Latency: header at FIFO head appears on link_o.v the next cycle. Minimum node latency is 2 cycles, link_i.v to link_o.v.
- Boundaries:
  - len = 2^len_width_p-1 handled (counter len_width_p bits wide).
  - FIFO full deasserts ready the same cycle it becomes full; simultaneous enq+deq when full is not allowed (ready already low).
  - packets_o wraps 2^32-1 -> 0.
  - en_i falling in IDLE with a header waiting: header is held and nothing is dequeued.
  - Reset mid-packet: the partial packet is discarded and FSM returns to IDLE. The bench must reset the router together with this block.
- Nets are fully independent; no shared state.

Optional Feature:
- Macro BSG_WH_TEST_CLIENT_CORD_CHECK_EN.
- Defined:
  - each header dequeued in IDLE is compared against my_cord_i;
  - on mismatch, error_o[i] is set sticky (cleared only by reset) and $error reports net, received cord and my_cord_i;
  - the packet is still looped back.
- Undefined: no compare logic; error_o tied 0.

Test Plan:
- Single-flit loopback: num_nets_p=2, one header on net0, cord=my_cord_i=5, return_cord_i=3, data=0xA5 -> link_o net0 v one flit, cord=3, len=0, data=0xA5, 2 cycles after input; packets_o[0]=1, packets_o[1]=0.
- Multi-flit packet: header len=3, three body flits 0x1,0x2,0x3, router ready held 1 -> 4 consecutive output flits, bodies bit-identical, busy_o high for 3 cycles, packets_o=1.
- Backpressure: link_i.ready_and_rev=0 for 10 cycles during the len=3 packet -> input ready drops after fifo_els_p+1 flits accepted; no flit lost or duplicated once ready returns.
- Stall via enable: en_i[0]=0 with a header queued -> no output for 20 cycles; en_i=1 -> packet emitted. en_i dropped mid-BODY -> packet still completes.
- Reset mid-packet: reset_n_i low during BODY after 1 of 3 body flits -> link_o.v=0 immediately, counters 0; next packet returns cleanly.
- With CORD_CHECK_EN: header cord 6, my_cord_i=5 -> error_o[0]=1 next cycle and stays 1; packet still returned. Without the macro, error_o stays 0.

Source files
------------

// File: rtl/bsg_wormhole_test_node_client_if.sv
// Wormhole link bundle for num_nets_p parallel ready/valid channels.
//   v             : per-net flit valid
//   data          : per-net flit payload
//   ready_and_rev : per-net ready travelling in the reverse direction
// The sender of v/data is also the sender of ready_and_rev for the opposite
// direction, so a node drives one bundle (master) and listens to one (slave).
interface bsg_wormhole_test_node_client_if #(
    parameter int unsigned flit_width_p = 16,
    parameter int unsigned num_nets_p   = 2
);
    logic [num_nets_p-1:0]                   v;
    logic [num_nets_p-1:0][flit_width_p-1:0] data;
    logic [num_nets_p-1:0]                   ready_and_rev;

    modport master (output v, output data, output ready_and_rev);
    modport slave  (input v, input data, input ready_and_rev);
endinterface

// File: rtl/bsg_wormhole_test_node_client.sv
// Loopback client node for the wormhole test network. Each net buffers
// incoming flits, rewrites the header cord to return_cord_i and sends every
// flit straight back, counting completed packets.
//
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   en_i             : per-net enable for launching new packets
//   my_cord_i        : own coordinate (header check only)
//   return_cord_i    : cord written into returned headers
//   link_i           : router-to-node bundle (flits in, router ready)
//   link_o           : node-to-router bundle (flits out, our ready)
//   packets_o        : per-net returned packet count (wraps)
//   busy_o           : per-net mid-packet flag
//   error_o          : per-net sticky header cord mismatch
//
// Optional: define BSG_WH_TEST_CLIENT_CORD_CHECK_EN to compare each header
// cord against my_cord_i; otherwise error_o is tied low.
module bsg_wormhole_test_node_client #(
    parameter int unsigned flit_width_p = 16,
    parameter int unsigned cord_width_p = 4,
    parameter int unsigned len_width_p  = 2,
    parameter int unsigned num_nets_p   = 2,
    parameter int unsigned fifo_els_p   = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_nets_p-1:0]            en_i,
    input  logic [cord_width_p-1:0]          my_cord_i,
    input  logic [cord_width_p-1:0]          return_cord_i,
    bsg_wormhole_test_node_client_if.slave   link_i,
    bsg_wormhole_test_node_client_if.master  link_o,
    output logic [num_nets_p-1:0][31:0]      packets_o,
    output logic [num_nets_p-1:0]            busy_o,
    output logic [num_nets_p-1:0]            error_o
);

    localparam int unsigned PtrW = $clog2(fifo_els_p);
    localparam logic [PtrW:0]          PtrOne = 1;
    localparam logic [len_width_p-1:0] LenOne = 1;

    typedef enum logic {StIdle, StBody} state_e;

    logic [num_nets_p-1:0]                   w_out_v;
    logic [num_nets_p-1:0][flit_width_p-1:0] w_out_data;
    logic [num_nets_p-1:0]                   w_ready;
    logic [num_nets_p-1:0]                   w_error;

    assign link_o.v             = w_out_v;
    assign link_o.data          = w_out_data;
    assign link_o.ready_and_rev = w_ready;
    assign error_o              = w_error;

    for (genvar n = 0; n < num_nets_p; n++) begin : g_net
        state_e                  r_state, w_state_d;
        logic [flit_width_p-1:0] r_mem [fifo_els_p];
        logic [PtrW:0]           r_wptr, r_rptr;
        logic                    w_full, w_empty, w_enq, w_deq, w_out_free;
        logic [flit_width_p-1:0] w_head, w_out_data_d;
        logic                    r_out_v;
        logic [flit_width_p-1:0] r_out_data;
        logic [len_width_p-1:0]  r_rem, w_rem_d;
        logic                    w_pkt_done;
        logic [31:0]             r_pkts;

        // Extra pointer bit distinguishes full from empty.
        assign w_empty = (r_wptr == r_rptr);
        assign w_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                         (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);

        // Gated by reset so the router sees no ready while we are held.
        assign w_ready[n]  = ~w_full & reset_n_i;
        assign w_enq       = link_i.v[n] & w_ready[n];
        assign w_head      = r_mem[r_rptr[PtrW-1:0]];
        // Output register can take a flit if empty or being consumed now.
        assign w_out_free  = ~r_out_v | link_i.ready_and_rev[n];

        always_comb begin
            w_state_d    = r_state;
            w_deq        = 1'b0;
            w_rem_d      = r_rem;
            w_out_data_d = w_head;
            w_pkt_done   = 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!w_empty && en_i[n] && w_out_free) begin
                        w_deq        = 1'b1;
                        w_out_data_d = {w_head[flit_width_p-1:cord_width_p], return_cord_i};
                        w_rem_d      = w_head[cord_width_p +: len_width_p];
                        if (w_rem_d == '0) begin
                            w_pkt_done = 1'b1;
                        end else begin
                            w_state_d = StBody;
                        end
                    end
                end
                StBody: begin
                    // en_i is ignored so a started packet never blocks the wormhole.
                    if (!w_empty && w_out_free) begin
                        w_deq   = 1'b1;
                        w_rem_d = r_rem - LenOne;
                        if (r_rem == LenOne) begin
                            w_pkt_done = 1'b1;
                            w_state_d  = StIdle;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_state    <= StIdle;
                r_rem      <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_out_v    <= 1'b0;
                r_out_data <= '0;
                r_pkts     <= '0;
            end else begin
                r_state <= w_state_d;
                r_rem   <= w_rem_d;
                if (w_enq) begin
                    r_wptr <= r_wptr + PtrOne;
                end
                if (w_deq) begin
                    r_rptr     <= r_rptr + PtrOne;
                    r_out_v    <= 1'b1;
                    r_out_data <= w_out_data_d;
                end else if (link_i.ready_and_rev[n]) begin
                    r_out_v <= 1'b0;
                end
                if (w_pkt_done) begin
                    r_pkts <= r_pkts + 32'd1;
                end
            end
        end

        // Storage needs no reset; pointers define validity.
        always_ff @(posedge clk_i) begin
            if (w_enq) begin
                r_mem[r_wptr[PtrW-1:0]] <= link_i.data[n];
            end
        end

        assign w_out_v[n]    = r_out_v;
        assign w_out_data[n] = r_out_data;
        assign packets_o[n]  = r_pkts;
        assign busy_o[n]     = (r_state == StBody);

`ifdef BSG_WH_TEST_CLIENT_CORD_CHECK_EN
        logic r_err;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_err <= 1'b0;
            end else if ((r_state == StIdle) && w_deq &&
                         (w_head[cord_width_p-1:0] != my_cord_i)) begin
                r_err <= 1'b1;
                $error("net %0d: header cord %0d does not match my_cord %0d",
                       n, w_head[cord_width_p-1:0], my_cord_i);
            end
        end
        assign w_error[n] = r_err;
`else
        assign w_error[n] = 1'b0;
`endif
    end

`ifndef BSG_WH_TEST_CLIENT_CORD_CHECK_EN
    logic w_unused_my_cord;
    assign w_unused_my_cord = ^my_cord_i;
`endif

endmodule

// File: tb/tb_bsg_wormhole_test_node_client.sv
// Self-checking bench for bsg_wormhole_test_node_client. The bench acts as the
// router: it sends packets, applies backpressure and records returned flits.
// Expected flits come from the packet rules: header cord becomes the return
// cord, every other bit and every body flit comes back unchanged, in order.
module tb_bsg_wormhole_test_node_client;

    localparam int FW = 16;
    localparam int CW = 4;
    localparam int LW = 2;
    localparam int NN = 2;
    localparam int FE = 2;

    typedef logic [FW-1:0] flit_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NN-1:0]     en;
    logic [CW-1:0]     my_cord, ret_cord;
    logic [NN-1:0][31:0] packets;
    logic [NN-1:0]     busy, err;

    bsg_wormhole_test_node_client_if #(.flit_width_p(FW), .num_nets_p(NN)) lnk_in ();
    bsg_wormhole_test_node_client_if #(.flit_width_p(FW), .num_nets_p(NN)) lnk_out ();

    bsg_wormhole_test_node_client #(
        .flit_width_p (FW),
        .cord_width_p (CW),
        .len_width_p  (LW),
        .num_nets_p   (NN),
        .fifo_els_p   (FE)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .en_i          (en),
        .my_cord_i     (my_cord),
        .return_cord_i (ret_cord),
        .link_i        (lnk_in),
        .link_o        (lnk_out),
        .packets_o     (packets),
        .busy_o        (busy),
        .error_o       (err)
    );

    initial forever #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;
    flit_t   got_q [NN][$];
    longint  got_cyc [NN][$];
    flit_t   tx_q [NN][$];
    flit_t   exp_q [NN][$];
    int      busy_cnt [NN];
    int      acc_cnt [NN];
    int      exp_pkts [NN];

    // Monitor: transfers complete at the next posedge; inputs only change at
    // posedge+1, so the negedge view is stable.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            for (int n = 0; n < NN; n++) begin
                if (lnk_out.v[n] && lnk_in.ready_and_rev[n]) begin
                    got_q[n].push_back(lnk_out.data[n]);
                    got_cyc[n].push_back(cyc);
                end
                if (busy[n]) busy_cnt[n]++;
                if (lnk_in.v[n] && lnk_out.ready_and_rev[n]) acc_cnt[n]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic flit_t mk_hdr(input logic [CW-1:0] cord, input logic [LW-1:0] len,
                                     input logic [FW-CW-LW-1:0] d);
        return {d, len, cord};
    endfunction

    function automatic flit_t returned(input flit_t f);
        return {f[FW-1:CW], ret_cord};
    endfunction

    // Queue a packet for transmission and its expected return.
    function automatic void add_pkt(input int net, input logic [CW-1:0] cord,
                                    input logic [LW-1:0] len);
        flit_t h, b;
        h = mk_hdr(cord, len, (FW-CW-LW)'($urandom_range(0, 1023)));
        tx_q[net].push_back(h);
        exp_q[net].push_back(returned(h));
        for (int i = 0; i < int'(len); i++) begin
            b = flit_t'($urandom);
            tx_q[net].push_back(b);
            exp_q[net].push_back(b);
        end
        exp_pkts[net]++;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the flit is accepted.
    task automatic drive_flit(input int net, input flit_t f);
        logic acc;
        int   g;
        lnk_in.v[net]    = 1'b1;
        lnk_in.data[net] = f;
        g = 0;
        forever begin
            @(negedge clk);
            acc = lnk_out.ready_and_rev[net];
            sync();
            if (acc) break;
            g++;
            if (g > 500) begin
                checks++;
                errors++;
                $display("FAIL drive_net%0d: flit %h not accepted in 500 cycles", net, f);
                break;
            end
        end
        lnk_in.v[net] = 1'b0;
    endtask

    task automatic send_q(input int net);
        flit_t f;
        while (tx_q[net].size() > 0) begin
            f = tx_q[net].pop_front();
            drive_flit(net, f);
        end
    endtask

    task automatic wait_got(input int net, input int n);
        for (int i = 0; i < 600 && got_q[net].size() < n; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        sync();
    endtask

    task automatic clear_bench();
        for (int n = 0; n < NN; n++) begin
            got_q[n].delete();
            got_cyc[n].delete();
            tx_q[n].delete();
            exp_q[n].delete();
            busy_cnt[n] = 0;
            acc_cnt[n]  = 0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (lnk_out.v !== '0) begin errors++;
            $display("FAIL reset_v: got %b want 00", lnk_out.v); end
        checks++; if (lnk_out.ready_and_rev !== '0) begin errors++;
            $display("FAIL reset_ready: got %b want 00", lnk_out.ready_and_rev); end
        checks++; if (packets !== '0) begin errors++;
            $display("FAIL reset_packets: got %h want 0", packets); end
        checks++; if (busy !== '0 || err !== '0) begin errors++;
            $display("FAIL reset_busy_err: got %b/%b want 00/00", busy, err); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (lnk_out.ready_and_rev !== 2'b11) begin errors++;
            $display("FAIL post_reset_ready: got %b want 11", lnk_out.ready_and_rev); end
        sync();
    endtask

    task automatic test_single();
        flit_t h;
        int    lat;
        clear_bench();
        h = mk_hdr(4'd5, 2'd0, 10'hA5);
        exp_pkts[0]++;
        lat = 0;
        fork
            drive_flit(0, h);
            begin
                @(negedge clk);
                while (!lnk_out.v[0] && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        checks++; if (lat != 2) begin errors++;
            $display("FAIL single_latency: got %0d want 2", lat); end
        wait_got(0, 1);
        checks++; if (got_q[0].size() != 1) begin errors++;
            $display("FAIL single_count: got %0d want 1", got_q[0].size()); end
        else begin
            checks++; if (got_q[0][0] !== mk_hdr(4'd3, 2'd0, 10'hA5)) begin errors++;
                $display("FAIL single_flit: got %h want %h", got_q[0][0],
                         mk_hdr(4'd3, 2'd0, 10'hA5)); end
        end
        checks++; if (got_q[1].size() != 0) begin errors++;
            $display("FAIL single_net1_quiet: got %0d flits want 0", got_q[1].size()); end
        checks++; if (packets[0] !== 32'd1 || packets[1] !== 32'd0) begin errors++;
            $display("FAIL single_packets: got %0d/%0d want 1/0", packets[0], packets[1]); end
    endtask

    task automatic test_multi();
        flit_t h;
        clear_bench();
        h = mk_hdr(4'd5, 2'd3, (FW-CW-LW)'($urandom_range(0, 1023)));
        tx_q[0] = '{h, 16'h1, 16'h2, 16'h3};
        exp_q[0] = '{returned(h), 16'h1, 16'h2, 16'h3};
        exp_pkts[0]++;
        send_q(0);
        wait_got(0, 4);
        checks++; if (got_q[0].size() != 4) begin errors++;
            $display("FAIL multi_count: got %0d want 4", got_q[0].size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[0][i] !== exp_q[0][i]) begin errors++;
                    $display("FAIL multi_flit%0d: got %h want %h", i, got_q[0][i], exp_q[0][i]); end
            end
            checks++; if (got_cyc[0][3] - got_cyc[0][0] != 3) begin errors++;
                $display("FAIL multi_consecutive: span %0d want 3", got_cyc[0][3] - got_cyc[0][0]); end
        end
        checks++; if (busy_cnt[0] != 3) begin errors++;
            $display("FAIL multi_busy: got %0d cycles want 3", busy_cnt[0]); end
        checks++; if (packets[0] !== 32'(exp_pkts[0])) begin errors++;
            $display("FAIL multi_packets: got %0d want %0d", packets[0], exp_pkts[0]); end
    endtask

    task automatic test_backpressure();
        clear_bench();
        add_pkt(0, my_cord, 2'd3);
        lnk_in.ready_and_rev[0] = 1'b0;
        fork
            send_q(0);
            begin
                repeat (10) @(negedge clk);
                checks++; if (acc_cnt[0] != FE + 1) begin errors++;
                    $display("FAIL bp_accepted: got %0d want %0d", acc_cnt[0], FE + 1); end
                checks++; if (lnk_out.ready_and_rev[0] !== 1'b0) begin errors++;
                    $display("FAIL bp_ready: got %b want 0", lnk_out.ready_and_rev[0]); end
                sync();
                lnk_in.ready_and_rev[0] = 1'b1;
            end
        join
        wait_got(0, 4);
        checks++; if (got_q[0].size() != 4) begin errors++;
            $display("FAIL bp_count: got %0d want 4", got_q[0].size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[0][i] !== exp_q[0][i]) begin errors++;
                    $display("FAIL bp_flit%0d: got %h want %h", i, got_q[0][i], exp_q[0][i]); end
            end
        end
    endtask

    task automatic test_enable();
        int g;
        clear_bench();
        en[0] = 1'b0;
        add_pkt(0, my_cord, 2'd0);
        send_q(0);
        repeat (20) @(negedge clk);
        checks++; if (got_q[0].size() != 0 || lnk_out.v[0] !== 1'b0) begin errors++;
            $display("FAIL en_stall: got %0d flits v=%b want 0/0", got_q[0].size(), lnk_out.v[0]); end
        sync();
        en[0] = 1'b1;
        wait_got(0, 1);
        checks++; if (got_q[0].size() != 1 || got_q[0][0] !== exp_q[0][0]) begin errors++;
            $display("FAIL en_release: got %0d flits want 1 of %h", got_q[0].size(), exp_q[0][0]); end
        clear_bench();
        add_pkt(0, my_cord, 2'd3);
        fork
            send_q(0);
            begin
                g = 0;
                while (!busy[0] && g < 100) begin @(negedge clk); g++; end
                sync();
                en[0] = 1'b0;
            end
        join
        wait_got(0, 4);
        checks++; if (got_q[0].size() != 4) begin errors++;
            $display("FAIL en_midbody_count: got %0d want 4", got_q[0].size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[0][i] !== exp_q[0][i]) begin errors++;
                    $display("FAIL en_midbody_flit%0d: got %h want %h", i, got_q[0][i], exp_q[0][i]); end
            end
        end
        checks++; if (busy[0] !== 1'b0 || packets[0] !== 32'(exp_pkts[0])) begin errors++;
            $display("FAIL en_midbody_done: busy %b pkts %0d want 0/%0d", busy[0], packets[0],
                     exp_pkts[0]); end
        en[0] = 1'b1;
    endtask

    task automatic test_reset_mid();
        flit_t h;
        clear_bench();
        h = mk_hdr(my_cord, 2'd3, 10'h155);
        drive_flit(0, h);
        drive_flit(0, 16'hBEEF);
        wait_got(0, 2);
        lnk_in.ready_and_rev[0] = 1'b0;
        drive_flit(0, 16'hCAFE);
        repeat (2) sync();
        checks++; if (lnk_out.v[0] !== 1'b1 || busy[0] !== 1'b1) begin errors++;
            $display("FAIL rstmid_pre: v %b busy %b want 1/1", lnk_out.v[0], busy[0]); end
        rst_n = 1'b0;
        lnk_in.v = '0;
        #1;
        checks++; if (lnk_out.v !== '0 || busy !== '0) begin errors++;
            $display("FAIL rstmid_v: v %b busy %b want 00/00", lnk_out.v, busy); end
        checks++; if (packets !== '0) begin errors++;
            $display("FAIL rstmid_packets: got %h want 0", packets); end
        exp_pkts = '{default: 0};
        lnk_in.ready_and_rev = '1;
        repeat (2) sync();
        rst_n = 1'b1;
        sync();
        clear_bench();
        add_pkt(0, my_cord, 2'($urandom_range(0, 3)));
        send_q(0);
        wait_got(0, exp_q[0].size());
        checks++; if (got_q[0].size() != exp_q[0].size()) begin errors++;
            $display("FAIL rstmid_after_count: got %0d want %0d", got_q[0].size(),
                     exp_q[0].size()); end
        else begin
            for (int i = 0; i < exp_q[0].size(); i++) begin
                checks++; if (got_q[0][i] !== exp_q[0][i]) begin errors++;
                    $display("FAIL rstmid_after_flit%0d: got %h want %h", i, got_q[0][i],
                             exp_q[0][i]); end
            end
        end
        checks++; if (packets[0] !== 32'd1) begin errors++;
            $display("FAIL rstmid_after_packets: got %0d want 1", packets[0]); end
    endtask

    task automatic test_random();
        logic stop;
        clear_bench();
        stop = 1'b0;
        for (int p = 0; p < 8; p++) begin
            for (int n = 0; n < NN; n++) add_pkt(n, my_cord, 2'($urandom_range(0, 3)));
        end
        fork
            begin
                fork
                    send_q(0);
                    send_q(1);
                join
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    sync();
                    lnk_in.ready_and_rev = 2'($urandom);
                    en = 2'($urandom);
                end
                lnk_in.ready_and_rev = '1;
                en = '1;
            end
        join
        for (int n = 0; n < NN; n++) begin
            wait_got(n, exp_q[n].size());
            checks++; if (got_q[n].size() != exp_q[n].size()) begin errors++;
                $display("FAIL rand_net%0d_count: got %0d want %0d", n, got_q[n].size(),
                         exp_q[n].size()); end
            else begin
                for (int i = 0; i < exp_q[n].size(); i++) begin
                    checks++; if (got_q[n][i] !== exp_q[n][i]) begin errors++;
                        $display("FAIL rand_net%0d_flit%0d: got %h want %h", n, i, got_q[n][i],
                                 exp_q[n][i]); end
                end
            end
            checks++; if (packets[n] !== 32'(exp_pkts[n])) begin errors++;
                $display("FAIL rand_net%0d_packets: got %0d want %0d", n, packets[n],
                         exp_pkts[n]); end
        end
    endtask

    task automatic test_cord_check();
        logic exp_err;
`ifdef BSG_WH_TEST_CLIENT_CORD_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_bench();
        add_pkt(0, 4'd6, 2'd0);
        send_q(0);
        wait_got(0, 1);
        checks++; if (got_q[0].size() != 1 || got_q[0][0] !== exp_q[0][0]) begin errors++;
            $display("FAIL cord_loopback: got %0d flits want 1 of %h", got_q[0].size(),
                     exp_q[0][0]); end
        repeat (5) sync();
        checks++; if (err[0] !== exp_err || err[1] !== 1'b0) begin errors++;
            $display("FAIL cord_error: got %b want %b0", err, exp_err); end
    endtask

    initial begin
        en                   = '1;
        my_cord              = 4'd5;
        ret_cord             = 4'd3;
        lnk_in.v             = '0;
        lnk_in.data          = '0;
        lnk_in.ready_and_rev = '1;
        exp_pkts             = '{default: 0};
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_random();
        test_cord_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
